// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, FSM encodings and default reset PC for the fetch stage
package fetch_unit_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstAddrBus-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // free to issue the next fetch
    ST_WAIT = 2'd1,  // fetch granted, response pending
    ST_DROP = 2'd2   // fetch granted before a redirect; its response is discarded
  } fetch_state_e;

endpackage

// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - in-order {pc, instruction} queue between fetch and IF/ID
//
// Ports:
//   clk, rst      clock, async active-high reset
//   push_i        write push_data_i at the tail (ignored when full)
//   push_data_i   entry to write
//   pop_i         drop the head entry (ignored when empty)
//   flush_i       synchronous flush; wins over push and pop
//   count_o       number of valid entries
//   head_o        head entry; holds the last shown head while empty
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != CNT_FULL);
  assign do_pop  = pop_i && (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      // Remember the current head so the outputs hold it once the queue empties.
      if (count_q != '0) last_q <= mem_q[rd_ptr_q];
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (do_push) begin
          mem_q[wr_ptr_q] <= push_data_i;
          wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_q <= count_q + (PTR_W+1)'(1);
        else if (do_pop && !do_push) count_q <= count_q - (PTR_W+1)'(1);
      end
    end
  end

  assign count_o = count_q;
  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, one-outstanding memory fetch FSM, instruction queue
//
// Optional feature macro: FETCH_BYPASS_EN (response forwarded straight to IF/ID when the queue is empty).
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   mem_req_o, mem_addr_o       fetch request and word address
//   mem_gnt_i                   request accepted this cycle
//   mem_rvalid_i, mem_rdata_i   in-order fetch response
//   redirect_i, redirect_pc_i   taken branch/jump: flush and refetch from target
//   inst_valid_o, inst_o        head of the instruction queue
//   inst_pc_o                   PC of the head instruction
//   id_ready_i                  IF/ID accepts the head this cycle
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int DATA_W = InstBus,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              id_ready_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W+DATA_W-1:0] head;
  logic              push, fifo_push, pop, bypass;

  // Issue is gated on queue space so a returning response always has a slot.
  assign mem_req_o  = !rst && (state_q == ST_REQ) && (count < CNT_FULL) && !redirect_i;
  assign mem_addr_o = pc_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;
    unique case (state_q)
      ST_REQ: begin
        if (mem_req_o && mem_gnt_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + ADDR_W'(4);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          push    = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (mem_rvalid_i) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
    if (redirect_i) begin
      pc_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
      push = 1'b0;
      // A fetch still in flight must have its response swallowed.
      if (state_q == ST_WAIT) state_d = mem_rvalid_i ? ST_REQ : ST_DROP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

`ifdef FETCH_BYPASS_EN
  assign bypass = (count == '0) && (state_q == ST_WAIT) && mem_rvalid_i && !redirect_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed response consumed by IF/ID in the same cycle never enters the queue.
  assign fifo_push = push && !(bypass && id_ready_i);
  assign pop       = (count != '0) && id_ready_i && !redirect_i;

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i ({req_pc_q, mem_rdata_i}),
    .pop_i       (pop),
    .flush_i     (redirect_i),
    .count_o     (count),
    .head_o      (head)
  );

  assign inst_valid_o = (count != '0) || bypass;
  assign inst_o       = bypass ? mem_rdata_i : head[DATA_W-1:0];
  assign inst_pc_o    = bypass ? req_pc_q    : head[ADDR_W+DATA_W-1:DATA_W];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        id_ready_i = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (4),
    .RESET_PC (RST_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .id_ready_i    (id_ready_i)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pops    = 0;
  int lat     = 1;
  bit mem_auto = 1'b0;
  bit rand_gnt = 1'b0;
  logic [31:0] exp_pc;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] grants[$];

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;
  vec_t tbl[7];

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drv(input logic g, input logic rv, input logic [31:0] rd,
                     input logic rdy, input logic redir, input logic [31:0] rpc);
    mem_gnt_i     = g;
    mem_rvalid_i  = rv;
    mem_rdata_i   = rd;
    id_ready_i    = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
  endtask

  // Memory model: responds in order, lat cycles after each grant.
  task automatic mem_drive();
    mem_rvalid_i = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
    mem_rdata_i  = mem_rvalid_i ? hash(pend_addr[0]) : $urandom;
    mem_gnt_i    = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
    lat          = rand_gnt ? int'($urandom_range(1, 4)) : 1;
  endtask

  // Observe the current cycle at the negedge, then advance past the next posedge.
  // The reference is the architectural stream: consumed PCs run sequentially from
  // the last redirect target (or reset PC), each carrying that address's word.
  task automatic tick();
    @(negedge clk);
    if (redirect_i) check("req_during_redirect", 32'(mem_req_o), 32'd0);
    if (mem_req_o)  check("addr_align", 32'(mem_addr_o[1:0]), 32'd0);
    if (inst_valid_o && id_ready_i && !redirect_i) begin
      check("pop_pc", inst_pc_o, exp_pc);
      check("pop_inst", inst_o, hash(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (redirect_i) exp_pc = {redirect_pc_i[31:2], 2'b00};
    if (mem_auto && mem_rvalid_i && pend_addr.size() > 0) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (mem_req_o && mem_gnt_i) begin
      grants.push_back(mem_addr_o);
      if (mem_auto) begin
        pend_addr.push_back(mem_addr_o);
        pend_due.push_back(cyc + lat);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (mem_auto) mem_drive();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    mem_auto = 1'b0;
    rand_gnt = 1'b0;
    drv(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    pend_addr.delete();
    pend_due.delete();
    grants.delete();
    exp_pc = RST_PC;
    @(negedge clk);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_addr", mem_addr_o, RST_PC);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_pc", inst_pc_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int pops0;
    logic [31:0] g4;

    tbl[0] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0};
    tbl[1] = '{1'b1, 1'b1, hash(32'h100), 1'b1, 1'b0, 32'h104, 1'b0, 32'h0,   32'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h104, 1'b1, 32'h100, hash(32'h100)};
    tbl[3] = '{1'b1, 1'b1, hash(32'h104), 1'b1, 1'b0, 32'h108, 1'b0, 32'h100, hash(32'h100)};
    tbl[4] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h108, 1'b1, 32'h104, hash(32'h104)};
    tbl[5] = '{1'b1, 1'b1, hash(32'h108), 1'b1, 1'b0, 32'h10C, 1'b0, 32'h104, hash(32'h104)};
    tbl[6] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10C, 1'b1, 32'h108, hash(32'h108)};

    // Sequential fetch from RESET_PC, latency 1, IF/ID always ready.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drv(tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, tbl[i].rdy, 1'b0, '0);
      #2;
      check("tbl_req", 32'(mem_req_o), 32'(tbl[i].e_req));
      check("tbl_addr", mem_addr_o, tbl[i].e_addr);
      check("tbl_valid", 32'(inst_valid_o), 32'(tbl[i].e_valid));
      check("tbl_pc", inst_pc_o, tbl[i].e_pc);
      check("tbl_inst", inst_o, tbl[i].e_inst);
      tick();
    end

    // Queue fills with IF/ID stalled, then drains in order and fetching resumes.
    do_reset();
    mem_auto = 1'b1;
    drv(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 14; i++) tick();
    check("full_grants", 32'(grants.size()), 32'd4);
    check("full_req", 32'(mem_req_o), 32'd0);
    check("full_valid", 32'(inst_valid_o), 32'd1);
    check("full_head_pc", inst_pc_o, 32'h100);
    pops0 = pops;
    id_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    g4 = (grants.size() > 4) ? grants[4] : 32'hFFFF_FFFF;
    check("resume_addr", g4, 32'h110);
    check("drain_pops_ge4", 32'(pops - pops0 >= 4), 32'd1);

    // Redirect while waiting; the in-flight response arrives 3 cycles later and is dropped.
    do_reset();
    drv(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);           #2; check("t3_req0", 32'(mem_req_o), 32'd1); tick();
    drv(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h203);      #2; check("t3_req_redir", 32'(mem_req_o), 32'd0); tick();
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);         #2;
      check("t3_req_drop", 32'(mem_req_o), 32'd0);
      check("t3_valid_drop", 32'(inst_valid_o), 32'd0);
      tick();
    end
    drv(1'b1, 1'b1, hash(32'h100), 1'b1, 1'b0, '0); #2; check("t3_req_rv", 32'(mem_req_o), 32'd0); tick();
    drv(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);           #2;
    check("t3_req_new", 32'(mem_req_o), 32'd1);
    check("t3_addr_new", mem_addr_o, 32'h200);
    check("t3_no_stale", 32'(inst_valid_o), 32'd0);
    tick();
    drv(1'b1, 1'b1, hash(32'h200), 1'b1, 1'b0, '0); #2; check("t3_valid_wait", 32'(inst_valid_o), 32'd0); tick();
    drv(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);           #2;
    check("t3_valid_tgt", 32'(inst_valid_o), 32'd1);
    check("t3_pc_tgt", inst_pc_o, 32'h200);
    tick();

    // Redirect coinciding with rvalid while the queue holds two entries.
    do_reset();
    drv(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);            tick();
    drv(1'b1, 1'b1, hash(32'h100), 1'b0, 1'b0, '0); tick();
    drv(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);            tick();
    drv(1'b1, 1'b1, hash(32'h104), 1'b0, 1'b0, '0); tick();
    drv(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);            tick();
    drv(1'b1, 1'b1, hash(32'h108), 1'b0, 1'b1, 32'h300); #2;
    check("t4_valid_redir", 32'(inst_valid_o), 32'd1);
    check("t4_req_redir", 32'(mem_req_o), 32'd0);
    tick();
    drv(1'b1, 1'b0, '0, 1'b0, 1'b0, '0); #2;
    check("t4_flushed", 32'(inst_valid_o), 32'd0);
    check("t4_req_tgt", 32'(mem_req_o), 32'd1);
    check("t4_addr_tgt", mem_addr_o, 32'h300);
    tick();
    drv(1'b0, 1'b1, hash(32'h300), 1'b0, 1'b0, '0); #2; check("t4_valid_wait", 32'(inst_valid_o), 32'd0); tick();
    drv(1'b0, 1'b0, '0, 1'b1, 1'b0, '0); #2;
    check("t4_valid_tgt", 32'(inst_valid_o), 32'd1);
    check("t4_pc_tgt", inst_pc_o, 32'h300);
    tick();

    // Grant withheld for 5 cycles: request held, PC does not advance.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drv(1'b0, 1'b0, '0, 1'b1, 1'b0, '0); #2;
      check("t5_req_hold", 32'(mem_req_o), 32'd1);
      check("t5_addr_hold", mem_addr_o, 32'h100);
      tick();
    end
    drv(1'b1, 1'b0, '0, 1'b1, 1'b0, '0); #2; check("t5_addr_gnt", mem_addr_o, 32'h100); tick();
    drv(1'b0, 1'b0, '0, 1'b1, 1'b0, '0); #2; check("t5_pc_next", mem_addr_o, 32'h104); tick();
    drv(1'b0, 1'b1, hash(32'h100), 1'b1, 1'b0, '0); tick();
    drv(1'b0, 1'b0, '0, 1'b1, 1'b0, '0); #2; check("t5_pc_out", inst_pc_o, 32'h100); tick();

    // Reset during a pending fetch; a stale rvalid after release is ignored.
    do_reset();
    drv(1'b1, 1'b0, '0, 1'b0, 1'b0, '0); tick();
    drv(1'b1, 1'b0, '0, 1'b0, 1'b0, '0); #2; check("t6_wait", 32'(mem_req_o), 32'd0); tick();
    do_reset();
    drv(1'b0, 1'b0, '0, 1'b1, 1'b0, '0); #2;
    check("t6_req_rel", 32'(mem_req_o), 32'd1);
    check("t6_addr_rel", mem_addr_o, RST_PC);
    tick();
    drv(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, '0); #2; check("t6_valid_stale", 32'(inst_valid_o), 32'd0); tick();
    drv(1'b1, 1'b0, '0, 1'b1, 1'b0, '0); #2;
    check("t6_valid_after", 32'(inst_valid_o), 32'd0);
    check("t6_addr_first", mem_addr_o, RST_PC);
    tick();
    drv(1'b0, 1'b1, hash(32'h100), 1'b1, 1'b0, '0); #2; check("t6_valid_resp", 32'(inst_valid_o), 32'd0); tick();
    drv(1'b0, 1'b0, '0, 1'b1, 1'b0, '0); #2;
    check("t6_valid_first", 32'(inst_valid_o), 32'd1);
    check("t6_inst_first", inst_o, hash(32'h100));
    tick();

    // Randomized grants, latencies, stalls and redirects against the stream reference.
    do_reset();
    mem_auto = 1'b1;
    rand_gnt = 1'b1;
    mem_drive();
    pops0 = pops;
    for (int i = 0; i < 3000; i++) begin
      id_ready_i    = ($urandom_range(0, 3) != 0);
      redirect_i    = ($urandom_range(0, 29) == 0);
      redirect_pc_i = 32'h1000 + 32'($urandom_range(0, 1023));
      tick();
    end
    check("rand_progress", 32'(pops - pops0 > 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
